// File: rtl/trigger_pkg.sv
// Purpose : shared definitions for the trigger path (match-mode encodings).
// Latency : n/a (types and constants only).
// Backpr. : n/a.
// Contents: trg_mod_t - per-channel event mode carried on cfg_mod[2i +: 2].
package trigger_pkg;

    typedef enum logic [1:0] {
        TRG_MOD_LVL  = 2'd0,   // event = current level match
        TRG_MOD_RISE = 2'd1,   // event on 0->1 of the level match
        TRG_MOD_FALL = 2'd2,   // event on 1->0 of the level match
        TRG_MOD_ANY  = 2'd3    // event on any change of the level match
    } trg_mod_t;

endpackage

// File: rtl/trigger_match_channel.sv
// Purpose : one trigger match channel: masked compare, stage-1 match bit, edge detect.
// Latency : m1 one cycle after sti_transfer; evt is combinational from m1/prv.
// Backpr. : none; every transferred sample is captured.
// Ports   : clk, rst (async active-high); cfg_val/cfg_msk (SDW) compare setup;
//           cfg_mod, v1, seen (only with TRIGGER_MATCH_EDGE_EN) edge control;
//           sti_transfer/sti_data input sample; evt stage-2 event (comb).
// Macro   : TRIGGER_MATCH_EDGE_EN enables prv and the rise/fall/any modes.
module trigger_match_channel
    import trigger_pkg::*;
#(
    parameter int SDW = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [SDW-1:0] cfg_val,
    input  logic [SDW-1:0] cfg_msk,
`ifdef TRIGGER_MATCH_EDGE_EN
    input  trg_mod_t       cfg_mod,
    input  logic           v1,
    input  logic           seen,
`endif
    input  logic           sti_transfer,
    input  logic [SDW-1:0] sti_data,
    output logic           evt
);

    logic lvl;
    logic m1;

    // A val bit outside the mask makes this channel unmatchable; that is
    // deliberate and left uncorrected.
    assign lvl = ((sti_data & cfg_msk) == cfg_val);

    // m1 holds across idle cycles so idle gaps never fabricate edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m1 <= 1'b0;
        end else if (sti_transfer) begin
            m1 <= lvl;
        end
    end

`ifdef TRIGGER_MATCH_EDGE_EN
    logic prv;

    // prv follows only transferred samples, and mode changes leave it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prv <= 1'b0;
        end else if (v1) begin
            prv <= m1;
        end
    end

    always_comb begin
        evt = m1;
        case (cfg_mod)
            TRG_MOD_LVL:  evt = m1;
            TRG_MOD_RISE: evt = m1 & ~prv & seen;
            TRG_MOD_FALL: evt = ~m1 & prv & seen;
            TRG_MOD_ANY:  evt = (m1 ^ prv) & seen;
            default:      evt = m1;
        endcase
    end
`else
    assign evt = m1;
`endif

endmodule

// File: rtl/trigger_match.sv
// Purpose : TAW-channel value/mask trigger matcher producing a registered event vector.
// Latency : 2 cycles, sti_transfer at N -> sto_transfer at N+2, one sample per clock.
// Backpr. : none; every input transfer yields exactly one output transfer.
// Ports   : clk, rst (async active-high); cfg_val/cfg_msk (TAW*SDW), cfg_mod (TAW*2);
//           sti_transfer/sti_data input sample; sto_transfer/sto_tevent event output.
// Macro   : TRIGGER_MATCH_EDGE_EN enables edge modes; otherwise every channel is level.
module trigger_match
    import trigger_pkg::*;
#(
    parameter int SDW = 32,
    parameter int TAW = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [TAW*SDW-1:0] cfg_val,
    input  logic [TAW*SDW-1:0] cfg_msk,
    input  logic [TAW*2-1:0]   cfg_mod,
    input  logic               sti_transfer,
    input  logic [SDW-1:0]     sti_data,
    output logic               sto_transfer,
    output logic [TAW-1:0]     sto_tevent
);

    logic           v1;
    logic [TAW-1:0] evt;

`ifdef TRIGGER_MATCH_EDGE_EN
    // seen gates edge events until one sample has passed stage 2 since reset.
    logic seen;
`else
    // cfg_mod has no effect when only level matching is built.
    logic unused_mod;
    assign unused_mod = ^cfg_mod;
`endif

    for (genvar i = 0; i < TAW; i++) begin : g_ch
        trigger_match_channel #(
            .SDW (SDW)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .cfg_val      (cfg_val[i*SDW +: SDW]),
            .cfg_msk      (cfg_msk[i*SDW +: SDW]),
`ifdef TRIGGER_MATCH_EDGE_EN
            .cfg_mod      (trg_mod_t'(cfg_mod[2*i +: 2])),
            .v1           (v1),
            .seen         (seen),
`endif
            .sti_transfer (sti_transfer),
            .sti_data     (sti_data),
            .evt          (evt[i])
        );
    end

    // sto_tevent holds between transfers; consumers qualify with sto_transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1           <= 1'b0;
            sto_transfer <= 1'b0;
            sto_tevent   <= '0;
`ifdef TRIGGER_MATCH_EDGE_EN
            seen         <= 1'b0;
`endif
        end else begin
            v1           <= sti_transfer;
            sto_transfer <= v1;
            if (v1) begin
                sto_tevent <= evt;
`ifdef TRIGGER_MATCH_EDGE_EN
                seen       <= 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_trigger_match.sv
module tb_trigger_match;

    localparam int SDW = 32;
    localparam int TAW = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [TAW*SDW-1:0] cfg_val = '0;
    logic [TAW*SDW-1:0] cfg_msk = '0;
    logic [TAW*2-1:0]   cfg_mod = '0;
    logic               sti_transfer = 1'b0;
    logic [SDW-1:0]     sti_data = '0;
    logic               sto_transfer;
    logic [TAW-1:0]     sto_tevent;

    trigger_match #(.SDW(SDW), .TAW(TAW)) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_val      (cfg_val),
        .cfg_msk      (cfg_msk),
        .cfg_mod      (cfg_mod),
        .sti_transfer (sti_transfer),
        .sti_data     (sti_data),
        .sto_transfer (sto_transfer),
        .sto_tevent   (sto_tevent)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Per accepted sample: level match from the config at entry, edge from the
    // previous accepted sample's level, result due two edges later.
    typedef struct {
        int             due;
        logic [TAW-1:0] ev;
    } exp_t;

    exp_t           exp_q[$];
    int             cyc = 0;
    logic [TAW-1:0] ref_prev = '0;
    logic           ref_seen = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            ref_prev = '0;
            ref_seen = 1'b0;
        end else begin
            cyc = cyc + 1;
            if (sti_transfer) begin
                exp_t           e;
                logic [TAW-1:0] lvl;
                for (int i = 0; i < TAW; i++) begin
                    lvl[i] = ((sti_data & cfg_msk[i*SDW +: SDW]) == cfg_val[i*SDW +: SDW]);
`ifdef TRIGGER_MATCH_EDGE_EN
                    case (cfg_mod[2*i +: 2])
                        2'd1:    e.ev[i] = ref_seen && lvl[i] && !ref_prev[i];
                        2'd2:    e.ev[i] = ref_seen && !lvl[i] && ref_prev[i];
                        2'd3:    e.ev[i] = ref_seen && (lvl[i] != ref_prev[i]);
                        default: e.ev[i] = lvl[i];
                    endcase
`else
                    e.ev[i] = lvl[i];
`endif
                end
                e.due = cyc + 1;
                exp_q.push_back(e);
                ref_prev = lvl;
                ref_seen = 1'b1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [TAW-1:0] last_ev = '0;
    logic [TAW-1:0] got_q[$];
    int             out_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            check("rst_transfer", 32'(sto_transfer), 32'd0);
            check("rst_tevent", 32'(sto_tevent), 32'd0);
            last_ev = '0;
        end else begin
            logic exp_v;
            exp_t e;
            exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            check("transfer", 32'(sto_transfer), 32'(exp_v));
            if (exp_v) begin
                e = exp_q.pop_front();
                last_ev = e.ev;
            end
            check("tevent", 32'(sto_tevent), 32'(last_ev));
            if (sto_transfer) begin
                out_cnt++;
                got_q.push_back(sto_tevent);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [SDW-1:0] d);
        sti_transfer = 1'b1;
        sti_data     = d;
        @(posedge clk);
        #1;
        sti_transfer = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic got_bit(input string name, input int idx, input int ch, input logic exp);
        if (got_q.size() > idx) check(name, 32'(got_q[idx][ch]), 32'(exp));
        else check(name, 32'hDEAD, 32'(exp));
    endtask

    logic edge_on;
    logic any_hit;
    int   cnt0;

    initial begin
`ifdef TRIGGER_MATCH_EDGE_EN
        edge_on = 1'b1;
`else
        edge_on = 1'b0;
`endif
        // ch0 level A5/FF, ch1 rise 1/1, ch2 fall 1/1, ch3 any FFFFFFFF
        cfg_val = {32'hFFFF_FFFF, 32'h1, 32'h1, 32'h0000_00A5};
        cfg_msk = {32'hFFFF_FFFF, 32'h1, 32'h1, 32'h0000_00FF};
        cfg_mod = {2'd3, 2'd2, 2'd1, 2'd0};
        idle(3);
        rst = 1'b0;
        idle(2);

        // first-sample suppression after reset
        got_q.delete();
        send(32'hFFFF_FFFF);
        send(32'h0);
        idle(4);
        check("first_cnt", 32'(got_q.size()), 32'd2);
        got_bit("first_s0_ch3", 0, 3, 1'b1 & ~edge_on);
        got_bit("first_s1_ch3", 1, 3, edge_on ? 1'b1 : 1'b0);

        // level match, 2-cycle latency
        got_q.delete();
        send(32'h1234_56A5);
        send(32'h1234_56A4);
        idle(4);
        check("lvl_cnt", 32'(got_q.size()), 32'd2);
        got_bit("lvl_s0_ch0", 0, 0, 1'b1);
        got_bit("lvl_s1_ch0", 1, 0, 1'b0);

        // rise/fall with idle gap
        got_q.delete();
        cnt0 = out_cnt;
        send(32'h0);
        idle(3);
        send(32'h1);
        send(32'h1);
        send(32'h0);
        idle(4);
        check("rf_cnt", 32'(out_cnt - cnt0), 32'd4);
        got_bit("rf_s0_ch1", 0, 1, 1'b0);
        got_bit("rf_s1_ch1", 1, 1, 1'b1);
        got_bit("rf_s2_ch1", 2, 1, ~edge_on);
        got_bit("rf_s3_ch1", 3, 1, 1'b0);
        got_bit("rf_s0_ch2", 0, 2, 1'b0);
        got_bit("rf_s1_ch2", 1, 2, ~edge_on);
        got_bit("rf_s2_ch2", 2, 2, ~edge_on);
        got_bit("rf_s3_ch2", 3, 2, edge_on);

        // unmatchable channel: val bit outside mask
        cfg_val[31:0] = 32'h100;
        cfg_msk[31:0] = 32'h0FF;
        idle(1);
        got_q.delete();
        for (int d = 0; d < 512; d++) send(32'(d));
        idle(4);
        any_hit = 1'b0;
        foreach (got_q[k]) any_hit = any_hit | got_q[k][0];
        check("unmatch_cnt", 32'(got_q.size()), 32'd512);
        check("unmatch_hit", 32'(any_hit), 32'd0);

        // reset mid-stream with two samples in flight
        cnt0 = out_cnt;
        sti_transfer = 1'b1;
        sti_data     = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        sti_data = 32'h0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        sti_transfer = 1'b0;
        rst          = 1'b0;
        idle(4);
        check("rst_drop", 32'(out_cnt - cnt0), 32'd0);

        // suppression again after the mid-stream reset
        got_q.delete();
        send(32'hFFFF_FFFF);
        send(32'h0);
        idle(4);
        got_bit("rerst_s0_ch3", 0, 3, ~edge_on);
        got_bit("rerst_s1_ch3", 1, 3, edge_on);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
